mdu_core: RTL

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. Executes mult/multu/div/divu, optional multiply-accumulate ops, and mthi/mtlo. Holds HI/LO and serves mfhi/mflo reads. It drives the `busy` flag and accepts the `start` pulse that the D-stage hazard logic uses to stall md/mt/mf instructions.

---
 rtl/mdu_pkg.sv | 39 +++
 rtl/mdu_div32.sv | 34 +++
 rtl/mdu_core.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, state encoding and op classification for the multiply/divide unit.
// MDU_MADD_EN (optional define) makes MADD/MADDU/MSUB/MSUBU multicycle ops.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    typedef logic [0:0] mdu_state_t;
    localparam mdu_state_t ST_IDLE = 1'b0;
    localparam mdu_state_t ST_RUN  = 1'b1;

    function automatic logic is_multicycle(input logic [3:0] op);
        logic mc;
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: mc = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: mc = 1'b1;
`endif
            default: mc = 1'b0;
        endcase
        return mc;
    endfunction

    function automatic logic is_divide(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_div32.sv
// Combinational 32-bit signed/unsigned divider: quotient truncates toward zero,
// remainder follows the dividend's sign; divide-by-zero is flagged, results are 0.
module mdu_div32 (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // 0x80000000 / -1 falls out naturally: magnitude 2^31 negates back to itself.
    always_comb begin
        a_neg    = is_signed & dividend[31];
        b_neg    = is_signed & divisor[31];
        a_mag    = a_neg ? (32'd0 - dividend) : dividend;
        b_mag    = b_neg ? (32'd0 - divisor) : divisor;
        div_zero = (divisor == 32'd0);
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = div_zero ? 32'd0 : (a_mag / b_safe);
        r_mag    = div_zero ? 32'd0 : (a_mag % b_safe);
        quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        remainder = a_neg ? (32'd0 - r_mag) : r_mag;
    end

endmodule

// File: rtl/mdu_core.sv
// E-stage multiply/divide unit: computes at acceptance, holds busy for a fixed latency,
// then commits HI/LO. MDU_MADD_EN (optional define) enables multiply-accumulate ops.
module mdu_core
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    mdu_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] res;
    logic        res_wr;
    logic        accept;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_zero;

    mdu_div32 u_div (
        .dividend  (rs_val),
        .divisor   (rt_val),
        .is_signed (op == MDU_DIV),
        .quotient  (div_quo),
        .remainder (div_rem),
        .div_zero  (div_zero)
    );

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    assign accept = (state_q == ST_IDLE) && start && !flush && is_multicycle(op);

    always_comb begin
        res    = 64'd0;
        res_wr = 1'b1;
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV, MDU_DIVU: begin
                res    = {div_rem, div_quo};
                res_wr = !div_zero;
            end
`ifdef MDU_MADD_EN
            // Accumulate against HI/LO as they stand on the accepting cycle.
            MDU_MADD:  res = {hi_q, lo_q} + prod_s;
            MDU_MADDU: res = {hi_q, lo_q} + prod_u;
            MDU_MSUB:  res = {hi_q, lo_q} - prod_s;
            MDU_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
            default:   res = 64'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_RUN;
                    cnt_d     = is_divide(op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    pend_hi_d = res[63:32];
                    pend_lo_d = res[31:0];
                    pend_wr_d = res_wr;
                end else if (!start && !flush) begin
                    if (op == MDU_MTHI) hi_d = rs_val;
                    if (op == MDU_MTLO) lo_d = rs_val;
                end
            end
            default: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        mf_data = 32'd0;
        if (op == MDU_MFHI) mf_data = hi_q;
        if (op == MDU_MFLO) mf_data = lo_q;
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Hazard logic must stall md ops while busy; a start here is dropped.
    assert property (@(posedge clk) disable iff (!reset) !(state_q == ST_RUN && start))
        else $warning("mdu_core: start while busy ignored");

endmodule
